// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master/slave pair.
// FSM encodings and default word length.
package spi_pkg;

  typedef enum logic {
    s_IDLE,
    s_DATA
  } state_t;

  localparam int WORD_LEN = 8;

endpackage

// File: rtl/spi_slave_if.sv
// Bus and transmit/receive handshake bundle of the SPI slave.
// The master modport is the view of whatever drives the slave.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int p_WORD_LEN = WORD_LEN
);

  logic                  i_sclk;
  logic                  i_mosi;
  logic                  i_cs_n;
  logic                  o_miso;
  logic [p_WORD_LEN-1:0] i_data;
  logic                  i_dv;
  logic                  o_tx_ready;
  logic [p_WORD_LEN-1:0] o_data;
  logic                  o_dv;
  logic                  o_active;
  logic                  o_underrun;

  modport slave (
    input  i_sclk,
    input  i_mosi,
    input  i_cs_n,
    input  i_data,
    input  i_dv,
    output o_miso,
    output o_tx_ready,
    output o_data,
    output o_dv,
    output o_active,
    output o_underrun
  );

  modport master (
    output i_sclk,
    output i_mosi,
    output i_cs_n,
    output i_data,
    output i_dv,
    input  o_miso,
    input  o_tx_ready,
    input  o_data,
    input  o_dv,
    input  o_active,
    input  o_underrun
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer plus one delayed copy for edge strobes.
// rise/fall are single-cycle pulses in the local clock domain.
module spi_sync #(
  parameter int   p_STAGES = 2,
  parameter logic p_RST    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [p_STAGES-1:0] chain;
  logic                dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {p_STAGES{p_RST}};
      dly   <= p_RST;
    end else begin
      chain <= {chain[p_STAGES-2:0], d};
      dly   <= chain[p_STAGES-1];
    end
  end

  assign level = chain[p_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 MSB-first slave, oversampled by the local clock.
// Single-entry tx buffer, one-cycle rx valid pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int p_WORD_LEN    = WORD_LEN,
  parameter int p_SYNC_STAGES = 2
) (
  input logic        i_clk,
  input logic        i_rst_n,
  spi_slave_if.slave bus
);

  localparam int CW = $clog2(p_WORD_LEN);
  localparam logic [CW-1:0] LAST = CW'(p_WORD_LEN - 1);

  logic       sclk_rise;
  logic       sclk_fall;
  logic       mosi_s;
  logic       cs_rise;
  logic       cs_fall;
  logic       unused_sclk_lvl;
  logic       unused_cs_lvl;
  logic [1:0] unused_mosi_edge;

  spi_sync #(.p_STAGES(p_SYNC_STAGES), .p_RST(1'b0)) u_sclk (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (bus.i_sclk),
    .level (unused_sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.p_STAGES(p_SYNC_STAGES), .p_RST(1'b0)) u_mosi (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (bus.i_mosi),
    .level (mosi_s),
    .rise  (unused_mosi_edge[0]),
    .fall  (unused_mosi_edge[1])
  );

  spi_sync #(.p_STAGES(p_SYNC_STAGES), .p_RST(1'b1)) u_cs (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (bus.i_cs_n),
    .level (unused_cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [p_WORD_LEN-1:0] rx_sr;
  logic [p_WORD_LEN-1:0] tx_sr;
  logic [p_WORD_LEN-1:0] tx_buf;
  logic                  buf_full;
  logic                  load;
  logic [p_WORD_LEN-1:0] load_val;
  logic [p_WORD_LEN-1:0] rx_next;

  always_comb begin
    load = 1'b0;
    unique case (1'b1)
      state == s_IDLE: load = cs_fall;
      state == s_DATA:
        load = !cs_rise && sclk_fall && bit_cnt == '0;
      default: load = 1'b0;
    endcase
  end

  assign load_val = buf_full ? tx_buf : '0;
  assign rx_next  = {rx_sr[p_WORD_LEN-2:0], mosi_s};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= s_IDLE;
      bit_cnt        <= '0;
      rx_sr          <= '0;
      tx_sr          <= '0;
      tx_buf         <= '0;
      buf_full       <= 1'b0;
      bus.o_miso     <= 1'b0;
      bus.o_data     <= '0;
      bus.o_dv       <= 1'b0;
      bus.o_active   <= 1'b0;
      bus.o_underrun <= 1'b0;
    end else begin
      bus.o_dv       <= 1'b0;
      bus.o_underrun <= 1'b0;
      if (load) begin
        tx_sr          <= load_val;
        bus.o_miso     <= load_val[p_WORD_LEN-1];
        bus.o_underrun <= ~buf_full;
      end
      unique case (state)
        s_IDLE: begin
          bus.o_active <= 1'b0;
          if (cs_fall) begin
            state        <= s_DATA;
            bus.o_active <= 1'b1;
          end
        end
        s_DATA: begin
          if (cs_rise) begin
            state        <= s_IDLE;
            bit_cnt      <= '0;
            bus.o_miso   <= 1'b0;
            bus.o_active <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr <= rx_next;
            if (bit_cnt == LAST) begin
              bit_cnt    <= '0;
              bus.o_data <= rx_next;
              bus.o_dv   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            tx_sr      <= tx_sr << 1;
            bus.o_miso <= tx_sr[p_WORD_LEN-2];
          end
        end
        default: state <= s_IDLE;
      endcase
      // a load empties the buffer; a same-cycle capture refills it
      if (load)
        buf_full <= 1'b0;
      if (bus.i_dv && !buf_full) begin
        tx_buf   <= bus.i_data;
        buf_full <= 1'b1;
      end
    end
  end

  assign bus.o_tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural mode-0 master plus rx scoreboard.
// Expected rx words queue at stimulus time and pop on o_dv.
module tb_spi_slave;

  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_run  = 0;
  int n_fail = 0;
  int ur_cnt = 0;

  logic [7:0] exp_q[$];

  spi_slave_if #(.p_WORD_LEN(8)) bus ();

  spi_slave #(
    .p_WORD_LEN    (8),
    .p_SYNC_STAGES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] got,
                     logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [7:0] v);
    bus.i_data = v;
    bus.i_dv   = 1'b1;
    @(negedge clk);
    bus.i_dv   = 1'b0;
  endtask

  // last SCLK fall coincides with CS release, as the master does
  task automatic xfer(input logic [15:0] mo, input int n,
                      output logic [15:0] mi,
                      output logic act);
    mi = '0;
    act = 1'b0;
    bus.i_cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.i_mosi = mo[n-1-i];
      cyc(HALF);
      bus.i_sclk = 1'b1;
      mi = {mi[14:0], bus.o_miso};
      if (i == 0) act = bus.o_active;
      cyc(HALF);
      bus.i_sclk = 1'b0;
      if (i == n - 1) bus.i_cs_n = 1'b1;
    end
    bus.i_mosi = 1'b0;
    cyc(2 * HALF);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_dv) begin
        chk("dv_pending", 16'(exp_q.size() > 0), 16'd1);
        if (exp_q.size() > 0)
          chk("rx_word", 16'(bus.o_data),
              16'(exp_q.pop_front()));
      end
      if (bus.o_underrun) ur_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mi;
    logic        act;
    bus.i_sclk = 1'b0;
    bus.i_mosi = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_data = '0;
    bus.i_dv   = 1'b0;

    for (int i = 0; i < 6; i++) begin
      bus.i_sclk = ~bus.i_sclk;
      bus.i_mosi = ~bus.i_mosi;
      cyc(3);
    end
    chk("rst_miso", 16'(bus.o_miso), 16'd0);
    chk("rst_dv", 16'(bus.o_dv), 16'd0);
    chk("rst_ready", 16'(bus.o_tx_ready), 16'd1);
    chk("rst_active", 16'(bus.o_active), 16'd0);
    chk("rst_data", 16'(bus.o_data), 16'd0);
    bus.i_sclk = 1'b0;
    bus.i_mosi = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    ur_cnt = 0;
    push(8'hA5);
    cyc(1);
    chk("pre_ready", 16'(bus.o_tx_ready), 16'd0);
    exp_q.push_back(8'h3C);
    xfer(16'h003C, 8, mi, act);
    chk("lb_miso", mi, 16'h00A5);
    chk("lb_active", 16'(act), 16'd1);
    chk("lb_ready", 16'(bus.o_tx_ready), 16'd1);
    chk("lb_underrun", 16'(ur_cnt), 16'd0);

    ur_cnt = 0;
    exp_q.push_back(8'hFF);
    xfer(16'h00FF, 8, mi, act);
    chk("ur_miso", mi, 16'h0000);
    chk("ur_count", 16'(ur_cnt), 16'd1);

    ur_cnt = 0;
    push(8'h11);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    fork
      xfer(16'h817E, 16, mi, act);
      begin
        int k = 0;
        while (!bus.o_tx_ready && k < 400) begin
          @(negedge clk);
          k++;
        end
        chk("refill_wait", 16'(bus.o_tx_ready), 16'd1);
        push(8'h22);
      end
    join
    chk("b2b_miso", mi, 16'h1122);
    chk("b2b_underrun", 16'(ur_cnt), 16'd0);

    xfer(16'h0016, 5, mi, act);
    chk("abort_data", 16'(bus.o_data), 16'h007E);
    exp_q.push_back(8'hC3);
    xfer(16'h00C3, 8, mi, act);

    bus.i_data = 8'h55;
    bus.i_dv   = 1'b1;
    @(negedge clk);
    bus.i_data = 8'hAA;
    @(negedge clk);
    bus.i_dv   = 1'b0;
    cyc(1);
    chk("hs_ready", 16'(bus.o_tx_ready), 16'd0);
    exp_q.push_back(8'h0F);
    xfer(16'h000F, 8, mi, act);
    chk("hs_miso", mi, 16'h0055);

    cyc(10);
    chk("q_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-0, MSB-first slave. It consumes the serial bus driven by the team's SPI master (SCLK, MOSI, chip-select derived as ~o_active) and drives MISO back to it. All bus inputs are oversampled by the local clock through synchronizers. Received words are delivered as a one-cycle valid pulse. Transmit words come from a single-entry buffer loaded through a ready/valid handshake.

Parameters:
p_WORD_LEN, 8, bits per SPI word (≥2)
p_SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥2)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  synchronous active-low reset
i_sclk  input  1  SPI clock from master (asynchronous)
i_mosi  input  1  SPI data from master (asynchronous)
i_cs_n  input  1  active-low chip select (asynchronous)
o_miso  output  1  SPI data to master; 0 when not selected
i_data  input  p_WORD_LEN  next word to transmit
i_dv  input  1  i_data valid; accepted only when o_tx_ready=1
o_tx_ready  output  1  transmit buffer empty
o_data  output  p_WORD_LEN  last received word; held until next word
o_dv  output  1  one-cycle pulse: o_data updated
o_active  output  1  slave selected (synced cs_n low)
o_underrun  output  1  one-cycle pulse: word started with empty buffer

Behaviour:
- Clocking/reset: single clock i_clk; reset is synchronous, active-low on i_rst_n. On reset: o_miso=0, o_data=0, o_dv=0, o_active=0, o_underrun=0, o_tx_ready=1. Synchronizer flops reset to sclk=0, mosi=0, cs_n=1. State=s_IDLE, bit count=0, buffers cleared.
- Input conditioning:
  - i_sclk, i_mosi and i_cs_n each pass through p_SYNC_STAGES flops.
  - One further registered copy of sclk and cs_n provides edge detection: rise/fall = single-cycle strobes.
  - Bus timing requirement: SCLK half-period ≥ p_SYNC_STAGES+2 i_clk cycles.
- FSM states:
  - s_IDLE: o_active=0, o_miso=0. On synced cs_n falling → s_DATA. In the same cycle, load the tx shift register from the buffer and drive o_miso=MSB. If the buffer is empty, load all-zeros and pulse o_underrun.
  - s_DATA, sclk rising: rx shift register <= {rx[W-2:0], mosi_sync}; bit count +1. When the count reaches p_WORD_LEN: o_data <= completed word, o_dv=1 on the next cycle (latency 1 cycle after the detected edge), bit count → 0.
  - s_DATA, sclk falling, bit count≠0: tx shifts left by one; o_miso=new MSB.
  - s_DATA, sclk falling, bit count=0 (word boundary inside one CS): reload tx from buffer (underrun rules as above); o_miso=MSB. This supports back-to-back words.
  - s_DATA, synced cs_n rising → s_IDLE. A partial word is discarded with no o_dv. Bit count → 0, o_miso → 0.
- Transmit buffer:
  - i_dv while o_tx_ready=1 captures i_data and drops o_tx_ready on the next cycle.
  - i_dv while o_tx_ready=0 is ignored; the buffer is unchanged.
  - A consumption (word load) sets o_tx_ready=1 on the next cycle.
  - i_dv in the same cycle as a load from an empty buffer: the load uses zeros (underrun pulse), i_data is captured, and o_tx_ready=0 afterwards.
  - i_dv in the same cycle as a load from a full buffer is ignored (o_tx_ready was 0).
- Priority within one cycle: reset > cs_n rising > sclk edge > handshake.
- Simultaneous cs_n falling and sclk edge cannot occur in mode 0. If it does, cs_n handling wins and the sclk edge is dropped.
- Reset mid-transfer returns to the reset values immediately. The slave stays in s_IDLE until a fresh cs_n falling edge.

Decomposition:
- Shared package spi_pkg: state encodings s_IDLE/s_DATA, and the default word length constant shared with the master.
- One sub-module, spi_sync: a p_SYNC_STAGES-deep synchronizer with a registered delayed copy, outputting level, rise and fall strobes. Instantiated three times (edges unused for mosi).

Test Plan:
1. Reset: hold i_rst_n=0 while toggling i_sclk → o_miso=0, o_dv=0, o_tx_ready=1, o_active=0.
2. Basic loopback with the master (p_CLK_DIV=20): preload 8'hA5 into the slave, master sends 8'h3C → slave o_dv pulse with o_data=8'h3C; master o_data=8'hA5; o_tx_ready returns to 1.
3. Underrun: no preload, master sends 8'hFF → o_underrun pulses once at the cs_n fall; master receives 8'h00; slave o_data=8'hFF.
4. Back-to-back: model drives 16 SCLKs under one CS with MOSI 8'h81 then 8'h7E, refilling the buffer (8'h11, then 8'h22) between words → two o_dv pulses (8'h81, 8'h7E); MISO carries 8'h11 then 8'h22.
5. Abort: deassert cs_n after 5 SCLK rises → no o_dv, o_data unchanged; the next full word is received correctly.
6. Handshake: i_dv with 8'h55 then 8'hAA on consecutive cycles while the buffer is empty → 8'h55 captured, 8'hAA ignored; the next transfer sends 8'h55.
